// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared state encoding and default width for the serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_subtrator.sv
`default_nettype none
// ============================================================================
// Module   : subtrator
// Purpose  : Combinational full-subtractor cell, borrow twin of the adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module subtrator (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial A - B - Bin over WIDTH cycles using one subtractor cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, done_q;
  logic             w_cell_diff, w_cell_bout;

  subtrator u_cell (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Bin  (br_q),
    .Diff (w_cell_diff),
    .Bout (w_cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          br_d    = Bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // LSB-first: each difference bit enters at the MSB and walks down
        diff_d = {w_cell_diff, diff_q[WIDTH-1:1]};
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        br_d   = w_cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bout_d  = w_cell_bout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed and randomized checks of serial_subtractor vs. arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         busy, done, Bout;
  logic [W-1:0] Diff;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {borrow, difference} from plain signed integer arithmetic
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return {(r < 0), W'(r)};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit full);
    logic [W:0] e;
    e = ref_sub(a, b, bin);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k <= W) begin
        if (full) begin
          chk("busy", busy, 1);
          chk("done_early", done, 0);
        end
      end else begin
        chk("done", done, 1);
        chk("busy_in_done", busy, 0);
        chk("diff", Diff, e[W-1:0]);
        chk("bout", Bout, e[W]);
      end
    end
    @(posedge clk); #1;
    if (full) begin
      chk("idle_done", done, 0);
      chk("idle_diff_hold", Diff, e[W-1:0]);
    end
  endtask

  initial begin
    logic [W:0] e;
    bit         seen;
    bit         saw_any;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'd9,  4'd5,  1'b0, 1'b1);
    run_op(4'd3,  4'd7,  1'b0, 1'b1);
    run_op(4'd0,  4'd0,  1'b1, 1'b1);
    run_op(4'd15, 4'd15, 1'b0, 1'b1);

    // Start during SHIFT must be ignored
    e = ref_sub(4'd8, 4'd1, 1'b0);
    @(negedge clk);
    A = 4'd8; B = 4'd1; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 4'd2; B = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("ign_done_seen", seen, 1);
    chk("ign_diff", Diff, e[W-1:0]);
    chk("ign_bout", Bout, e[W]);
    @(posedge clk); #1;
    chk("ign_no_restart", busy, 0);

    // Asynchronous reset in the middle of SHIFT
    @(negedge clk);
    A = 4'd6; B = 4'd2; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", Diff, 0);
    chk("arst_bout", Bout, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_any = 1'b0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (done || busy) saw_any = 1'b1;
    end
    chk("arst_no_done", saw_any, 0);

    // Randomized operations
    repeat (20) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end

    // Start held high: one operation every W+2 cycles
    e = ref_sub(4'd10, 4'd3, 1'b0);
    @(negedge clk);
    A = 4'd10; B = 4'd3; Bin = 1'b0; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("held_done", done, ((c % (W + 2)) == (W + 1)));
      chk("held_busy", busy, ((c % (W + 2)) >= 1) && ((c % (W + 2)) <= W));
      if (done) begin
        chk("held_diff", Diff, e[W-1:0]);
        chk("held_bout", Bout, e[W]);
      end
    end
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("held_drain", seen, 1);
    @(posedge clk); #1;

    // Exhaustive sweep
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          run_op(W'(a), W'(b), 1'(bi), 1'b0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing A − B − Bin over WIDTH clock cycles. It uses one full-subtractor cell, the borrow counterpart of the team's full-adder cell. It is the sequential, inverse-operation partner of the 4-bit ripple-carry adder datapath and shares the same operand and borrow conventions. The intended use is board-level exercises where switches load the operands and LEDs show the difference and borrow-out.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥2)

Ports:
- clk  input  1  single system clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend, captured on accepted start
- B  input  WIDTH  subtrahend, captured on accepted start
- Bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when Diff/Bout become valid
- Diff  output  WIDTH  result (A − B − Bin) mod 2^WIDTH
- Bout  output  1  final borrow-out (1 when A < B + Bin, unsigned)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, load a_sr←A, b_sr←B, br←Bin, cnt←0; go to SHIFT.
- SHIFT: each cycle the cell takes a=a_sr[0], b=b_sr[0], br.
  - d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
  - Diff shifts right with d entering the MSB; a_sr/b_sr shift right; br←br_next; cnt++.
  - After WIDTH cycles (cnt==WIDTH−1 at the edge), go to DONE; Bout←br_next on that same edge.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Diff and Bout hold their last values in IDLE until the next accepted start. Diff is not cleared at start; it is fully overwritten by the WIDTH shifts.
- start in SHIFT or DONE is ignored; no queuing.
- Arithmetic is unsigned modulo 2^WIDTH. Bout is the sole underflow indicator.

## Timing
- Reset values: state=IDLE, busy=0, done=0, Diff=0, Bout=0, internal registers 0.
- Let the accepting edge be E0 (start=1 in IDLE). Then:
  - busy=1 for cycles following E0 through E_WIDTH, i.e. exactly WIDTH cycles.
  - done=1 for the single cycle after E_WIDTH.
  - The next start is accepted at E_(WIDTH+2) at the earliest.
- Latency from start to done-asserted is WIDTH+1 cycles. Diff/Bout are valid whenever done=1 and remain valid afterwards.
- busy and done are never high simultaneously. All outputs are registered.
- Reset asserted mid-operation (any state) aborts immediately and asynchronously. All outputs return to reset values and no done pulse is produced.
- start held high continuously produces back-to-back operations every WIDTH+2 cycles.

## Structure
- Package serial_subtractor_pkg: state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
- Sub-module subtrator: combinational full-subtractor cell with ports A, B, Bin, Diff, Bout. It mirrors the existing full-adder cell and is instantiated once.
- Top: FSM, operand shift registers, borrow flop, counter of width $clog2(WIDTH)+1.

## Test plan
- Reset, then A=9, B=5, Bin=0, start pulse -> done on the 5th cycle after the start edge, Diff=4, Bout=0, busy high for exactly 4 cycles.
- A=3, B=7, Bin=0 -> Diff=12 (4'b1100), Bout=1.
- A=0, B=0, Bin=1 -> Diff=15, Bout=1; then A=15, B=15, Bin=0 -> Diff=0, Bout=0.
- Start A=8, B=1; at cycle 2 drive start=1 with A=2, B=2 -> second request ignored; result Diff=7, Bout=0.
- Start A=6, B=2; assert rst asynchronously in cycle 2 of SHIFT -> busy, done, Diff and Bout all 0 immediately; no done pulse follows.
- start held high with A=10, B=3 -> done pulses every 6 cycles, each with Diff=7, Bout=0; exhaustive sweep of all A, B, Bin combinations against a reference model.
